// File: rtl/glyph_frame_renderer_if.sv
// Request/response bundle between the game logic and the glyph frame renderer.
// The collision signal exists only when COLLIDE_DETECT_EN is defined.
interface glyph_frame_renderer_if #(
  parameter int FB_W    = 40,
  parameter int FB_H    = 30,
  parameter int NUM_CH  = 3,
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 5,
  parameter int XW      = 6,
  parameter int YW      = 5
);
  logic                                start;
  logic [NUM_CH*GLYPH_W*GLYPH_H-1:0]   glyphs;
  logic [NUM_CH*XW-1:0]                xpos;
  logic [NUM_CH*YW-1:0]                ypos;
  logic [NUM_CH-1:0]                   visible;
  logic                                busy;
  logic                                done;
  logic [FB_W*FB_H-1:0]                framebuffer;
`ifdef COLLIDE_DETECT_EN
  logic                                collision;

  modport master (
    output start, glyphs, xpos, ypos, visible,
    input  busy, done, framebuffer, collision
  );
  modport slave (
    input  start, glyphs, xpos, ypos, visible,
    output busy, done, framebuffer, collision
  );
`else
  modport master (
    output start, glyphs, xpos, ypos, visible,
    input  busy, done, framebuffer
  );
  modport slave (
    input  start, glyphs, xpos, ypos, visible,
    output busy, done, framebuffer
  );
`endif
endinterface

// File: rtl/glyph_frame_renderer.sv
// Renders NUM_CH clipped glyphs one row per clock into a back buffer, then swaps it
// into the displayed framebuffer. Optional overlap flag: define COLLIDE_DETECT_EN.
module glyph_frame_renderer #(
  parameter int FB_W    = 40,
  parameter int FB_H    = 30,
  parameter int NUM_CH  = 3,
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 5,
  parameter int XW      = 6,
  parameter int YW      = 5
) (
  input logic                  clock,
  input logic                  resetn,
  glyph_frame_renderer_if.slave bus
);

  localparam int NPIX  = FB_W * FB_H;
  localparam int GBITS = GLYPH_W * GLYPH_H;
  localparam int IDXW  = $clog2(NPIX);
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RW    = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int XSW   = XW + 4;
  localparam int YSW   = YW + 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAW,
    ST_SWAP
  } state_t;

  state_t                  state_q, state_d;
  logic [CHW-1:0]          ch_q, ch_d;
  logic [RW-1:0]           r_q, r_d;
  logic [NUM_CH*GBITS-1:0] glyphs_q, glyphs_d;
  logic [NUM_CH*XW-1:0]    xpos_q, xpos_d;
  logic [NUM_CH*YW-1:0]    ypos_q, ypos_d;
  logic [NUM_CH-1:0]       visible_q, visible_d;
  logic [NPIX-1:0]         back_q, back_d;
  logic [NPIX-1:0]         fb_q, fb_d;
  logic                    done_q, done_d;
`ifdef COLLIDE_DETECT_EN
  logic                    flag_q, flag_d;
  logic                    coll_q, coll_d;
`endif

  // Per-channel views of the latched request.
  logic [GBITS-1:0] glyph_arr [NUM_CH];
  logic [XW-1:0]    x_arr     [NUM_CH];
  logic [YW-1:0]    y_arr     [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign glyph_arr[gi] = glyphs_q[gi*GBITS +: GBITS];
      assign x_arr[gi]     = xpos_q[gi*XW +: XW];
      assign y_arr[gi]     = ypos_q[gi*YW +: YW];
    end
  endgenerate

  logic [GBITS-1:0]   cur_glyph;
  logic [XW-1:0]      cur_x;
  logic [YW-1:0]      cur_y;
  logic               cur_vis;
  logic [GLYPH_W-1:0] row_bits;
  logic [YSW-1:0]     py;
  logic               row_in_range;

  assign cur_glyph    = glyph_arr[ch_q];
  assign cur_x        = x_arr[ch_q];
  assign cur_y        = y_arr[ch_q];
  assign cur_vis      = visible_q[ch_q];
  assign py           = YSW'(cur_y) + YSW'(r_q);
  assign row_in_range = (py < YSW'(FB_H));

  // Glyph row r sits at the top of the slice; an invisible channel draws nothing.
  always_comb begin
    row_bits = '0;
    for (int rr = 0; rr < GLYPH_H; rr++) begin
      if (r_q == RW'(rr)) begin
        row_bits = cur_glyph[(GLYPH_H-1-rr)*GLYPH_W +: GLYPH_W];
      end
    end
    if (!cur_vis) begin
      row_bits = '0;
    end
  end

  logic [GLYPH_W-1:0] col_hit;
  logic [IDXW-1:0]    col_idx [GLYPH_W];

  generate
    for (gi = 0; gi < GLYPH_W; gi++) begin : g_col
      logic [XSW-1:0] px;
      assign px          = XSW'(cur_x) + XSW'(gi);
      assign col_hit[gi] = row_bits[GLYPH_W-1-gi] && (px < XSW'(FB_W)) && row_in_range;
      assign col_idx[gi] = IDXW'(py) * IDXW'(FB_W) + IDXW'(px);
    end
  endgenerate

  logic [NPIX-1:0] row_mask;

  always_comb begin
    row_mask = '0;
    for (int cc = 0; cc < GLYPH_W; cc++) begin
      if (col_hit[cc]) begin
        row_mask[col_idx[cc]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      r_q       <= '0;
      glyphs_q  <= '0;
      xpos_q    <= '0;
      ypos_q    <= '0;
      visible_q <= '0;
      back_q    <= '0;
      fb_q      <= '0;
      done_q    <= 1'b0;
`ifdef COLLIDE_DETECT_EN
      flag_q    <= 1'b0;
      coll_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      r_q       <= r_d;
      glyphs_q  <= glyphs_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      visible_q <= visible_d;
      back_q    <= back_d;
      fb_q      <= fb_d;
      done_q    <= done_d;
`ifdef COLLIDE_DETECT_EN
      flag_q    <= flag_d;
      coll_q    <= coll_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    r_d       = r_q;
    glyphs_d  = glyphs_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    visible_d = visible_q;
    back_d    = back_q;
    fb_d      = fb_q;
    done_d    = 1'b0;
`ifdef COLLIDE_DETECT_EN
    flag_d    = flag_q;
    coll_d    = coll_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          glyphs_d  = bus.glyphs;
          xpos_d    = bus.xpos;
          ypos_d    = bus.ypos;
          visible_d = bus.visible;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        back_d  = '0;
        ch_d    = '0;
        r_d     = '0;
`ifdef COLLIDE_DETECT_EN
        flag_d  = 1'b0;
`endif
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        back_d = back_q | row_mask;
`ifdef COLLIDE_DETECT_EN
        if (|(row_mask & back_q)) begin
          flag_d = 1'b1;
        end
`endif
        // Every channel takes GLYPH_H cycles regardless of visibility, fixing latency.
        if (r_q == RW'(GLYPH_H-1)) begin
          r_d = '0;
          if (ch_q == CHW'(NUM_CH-1)) begin
            state_d = ST_SWAP;
          end else begin
            ch_d = ch_q + CHW'(1);
          end
        end else begin
          r_d = r_q + RW'(1);
        end
      end
      ST_SWAP: begin
        fb_d    = back_q;
        done_d  = 1'b1;
`ifdef COLLIDE_DETECT_EN
        coll_d  = flag_q;
`endif
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.framebuffer = fb_q;
`ifdef COLLIDE_DETECT_EN
  assign bus.collision   = coll_q;
`endif

endmodule
